// File: rtl/dmem_responder_if.sv
// dmem_responder_if: load/store bus between the LEGv8 datapath (master) and
// the data-memory responder (slave).
//   address   : byte address from the ALU result
//   writedata : store data; sub-word stores use the low bytes
//   memread   : load request, sampled at posedge
//   memwrite  : store request, sampled at posedge
//   size      : 00 byte, 01 half, 10 word, 11 doubleword
//   readdata  : registered, zero-extended load data
//   readvalid : one-cycle pulse qualifying readdata
//   fault     : one-cycle pulse for a misaligned or out-of-range access
interface dmem_responder_if;
    logic [63:0] address;
    logic [63:0] writedata;
    logic        memread;
    logic        memwrite;
    logic [1:0]  size;
    logic [63:0] readdata;
    logic        readvalid;
    logic        fault;

    modport master (
        output address, writedata, memread, memwrite, size,
        input  readdata, readvalid, fault
    );

    modport slave (
        input  address, writedata, memread, memwrite, size,
        output readdata, readvalid, fault
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: 64-bit LEGv8 data memory, slave side of the load/store bus.
// Little-endian, byte/half/word/doubleword accesses, one-cycle registered
// loads, read-before-write on simultaneous load/store, and a preload port
// that overrides same-cycle stores. Misaligned or out-of-range accesses leave
// memory untouched and pulse fault for one cycle.
// Ports:
//   CLK          : rising-edge clock
//   reset        : synchronous active-high reset (zeroes the whole array)
//   bus          : dmem_responder_if.slave load/store bus
//   preload_we   : preload strobe, writes a full word
//   preload_idx  : preload word index
//   preload_data : preload doubleword
//   rd_count / wr_count : saturating counts of successful loads/stores,
//                  present only when DMEM_STATS_EN is defined
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = 7
) (
    input  logic             CLK,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    input  logic             preload_we,
    input  logic [IDX_W-1:0] preload_idx,
    input  logic [63:0]      preload_data
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0]      rd_count,
    output logic [15:0]      wr_count
`endif
);

    logic [63:0]      mem_r [DEPTH_WORDS];
    logic [63:0]      readdata_r;
    logic             readvalid_r;
    logic             fault_r;

    logic [IDX_W-1:0] idx_s;
    logic [5:0]       shamt_s;
    logic             oor_s;
    logic             misalign_s;
    logic             fault_s;
    logic [63:0]      size_mask_s;
    logic [63:0]      lane_mask_s;
    logic [63:0]      old_word_s;
    logic [63:0]      rd_lane_s;
    logic [63:0]      merged_s;
    logic             store_ok_s;

    // Decode address, check alignment/range, and build load lane and store merge.
    always_comb begin
        idx_s      = bus.address[IDX_W+2:3];
        shamt_s    = {bus.address[2:0], 3'b000};
        oor_s      = |bus.address[63:IDX_W+3];
        misalign_s = 1'b0;
        size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
        case (bus.size)
            2'b00: begin
                misalign_s  = 1'b0;
                size_mask_s = 64'h0000_0000_0000_00FF;
            end
            2'b01: begin
                misalign_s  = bus.address[0];
                size_mask_s = 64'h0000_0000_0000_FFFF;
            end
            2'b10: begin
                misalign_s  = |bus.address[1:0];
                size_mask_s = 64'h0000_0000_FFFF_FFFF;
            end
            2'b11: begin
                misalign_s  = |bus.address[2:0];
                size_mask_s = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            default: begin
                misalign_s  = 1'b1;
                size_mask_s = 64'h0000_0000_0000_0000;
            end
        endcase
        fault_s     = misalign_s | oor_s;
        old_word_s  = mem_r[idx_s];
        // Zero-extended load: shift the addressed lane down, then trim to size.
        rd_lane_s   = (old_word_s >> shamt_s) & size_mask_s;
        // Store merge: only the lanes under the shifted mask take new bytes.
        lane_mask_s = size_mask_s << shamt_s;
        merged_s    = (old_word_s & ~lane_mask_s) | ((bus.writedata << shamt_s) & lane_mask_s);
        // A same-cycle preload drops the store regardless of index.
        store_ok_s  = bus.memwrite & ~fault_s & ~preload_we;
    end

    // Memory array and registered load/fault responses.
    always_ff @(posedge CLK) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= 64'h0;
            end
            readdata_r  <= 64'h0;
            readvalid_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            readvalid_r <= bus.memread;
            fault_r     <= (bus.memread | bus.memwrite) & fault_s;
            if (bus.memread) begin
                // Read uses the pre-update array, giving read-before-write.
                readdata_r <= fault_s ? 64'h0 : rd_lane_s;
            end
            if (preload_we) begin
                mem_r[preload_idx] <= preload_data;
            end else if (store_ok_s) begin
                mem_r[idx_s] <= merged_s;
            end
        end
    end

    assign bus.readdata  = readdata_r;
    assign bus.readvalid = readvalid_r;
    assign bus.fault     = fault_r;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_count_r;
    logic [15:0] wr_count_r;

    // Saturating counters of successful loads and committed stores.
    always_ff @(posedge CLK) begin
        if (reset) begin
            rd_count_r <= 16'h0;
            wr_count_r <= 16'h0;
        end else begin
            if (bus.memread && !fault_s && (rd_count_r != 16'hFFFF)) begin
                rd_count_r <= rd_count_r + 16'd1;
            end
            if (store_ok_s && (wr_count_r != 16'hFFFF)) begin
                wr_count_r <= wr_count_r + 16'd1;
            end
        end
    end

    assign rd_count = rd_count_r;
    assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a scoreboard queue of expected
// responses: each access pushes its expectation, the following edge pops it.
module tb_dmem_responder;

    logic       CLK;
    logic       reset;
    logic       preload_we;
    logic [6:0] preload_idx;
    logic [63:0] preload_data;
`ifdef DMEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    dmem_responder_if bus ();

    dmem_responder #(.DEPTH_WORDS(128), .IDX_W(7)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .bus          (bus),
        .preload_we   (preload_we),
        .preload_idx  (preload_idx),
        .preload_data (preload_data)
`ifdef DMEM_STATS_EN
        ,
        .rd_count     (rd_count),
        .wr_count     (wr_count)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rdv;
        logic [63:0] data;
        logic        flt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [63:0] last_rd  = 64'h0;
    int          exp_rd_cnt = 0;
    int          exp_wr_cnt = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.memread   = 1'b0;
        bus.memwrite  = 1'b0;
        bus.address   = 64'h0;
        bus.writedata = 64'h0;
        bus.size      = 2'b11;
        preload_we    = 1'b0;
        preload_idx   = 7'd0;
        preload_data  = 64'h0;
    endtask

    // One bus cycle: drive, push expectation, clock, pop and compare.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [63:0] addr, input logic [1:0] sz,
                          input logic [63:0] wd, input logic pl,
                          input logic [6:0] pidx, input logic [63:0] pdata,
                          input logic [63:0] exp_data, input logic exp_flt);
        exp_t e;
        exp_t got;
        bus.memread   = rd;
        bus.memwrite  = wr;
        bus.address   = addr;
        bus.size      = sz;
        bus.writedata = wd;
        preload_we    = pl;
        preload_idx   = pidx;
        preload_data  = pdata;
        e.rdv  = rd;
        e.flt  = exp_flt & (rd | wr);
        e.data = rd ? (exp_flt ? 64'h0 : exp_data) : last_rd;
        if (rd) last_rd = e.data;
        if (rd && !exp_flt) exp_rd_cnt++;
        if (wr && !exp_flt && !pl) exp_wr_cnt++;
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
        idle_inputs();
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            got = sb_q.pop_front();
            chk({tag, "_rdv"},   {63'd0, bus.readvalid}, {63'd0, got.rdv});
            chk({tag, "_fault"}, {63'd0, bus.fault},     {63'd0, got.flt});
            chk({tag, "_data"},  bus.readdata,           got.data);
        end
    endtask

    task automatic do_reset(input logic rd);
        reset       = 1'b1;
        bus.memread = rd;
        @(posedge CLK);
        #1;
        idle_inputs();
        chk("reset_rdv",   {63'd0, bus.readvalid}, 64'd0);
        chk("reset_fault", {63'd0, bus.fault},     64'd0);
        chk("reset_data",  bus.readdata,           64'd0);
        reset      = 1'b0;
        last_rd    = 64'h0;
        exp_rd_cnt = 0;
        exp_wr_cnt = 0;
        sb_q.delete();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        do_reset(1'b0);

        // Preload and full-word load.
        access("preload0", 1'b0, 1'b0, 64'h0, 2'b11, 64'h0, 1'b1, 7'd0, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
        access("ldur0",    1'b1, 1'b0, 64'h0, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
        // Byte store then reload.
        access("sturb5",   1'b0, 1'b1, 64'h5, 2'b00, 64'hFF, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("ldur0b",   1'b1, 1'b0, 64'h0, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0123_FF67_89AB_CDEF, 1'b0);
        // Misaligned half load, then idle deasserts fault.
        access("ldh3_mis", 1'b1, 1'b0, 64'h3, 2'b01, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b1);
        access("idle1",    1'b0, 1'b0, 64'h0, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        // Sub-word lane loads, zero-extended.
        access("ldb5",     1'b1, 1'b0, 64'h5, 2'b00, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0000_0000_0000_00FF, 1'b0);
        access("ldh4",     1'b1, 1'b0, 64'h4, 2'b01, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0000_0000_0000_FF67, 1'b0);
        access("ldw4",     1'b1, 1'b0, 64'h4, 2'b10, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0000_0000_0123_FF67, 1'b0);
        access("ldb7",     1'b1, 1'b0, 64'h7, 2'b00, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0000_0000_0000_0001, 1'b0);
        // Out-of-range and misaligned stores leave word 0 untouched.
        access("st400_oor", 1'b0, 1'b1, 64'h400, 2'b11, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 7'd0, 64'h0, 64'h0, 1'b1);
        access("stw2_mis",  1'b0, 1'b1, 64'h2, 2'b10, 64'hAAAA_AAAA, 1'b0, 7'd0, 64'h0, 64'h0, 1'b1);
        access("ld_hi_oor", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b1);
        access("ldur0c",   1'b1, 1'b0, 64'h0, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0123_FF67_89AB_CDEF, 1'b0);
        // Read-before-write.
        access("rw8",      1'b1, 1'b1, 64'h8, 2'b11, 64'hF, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("ld8",      1'b1, 1'b0, 64'h8, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'hF, 1'b0);
        // Preload wins over a store to another word.
        access("st10_pl3", 1'b0, 1'b1, 64'h10, 2'b11, 64'hAA, 1'b1, 7'd3, 64'h55, 64'h0, 1'b0);
        access("ld18",     1'b1, 1'b0, 64'h18, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h55, 1'b0);
        access("ld10",     1'b1, 1'b0, 64'h10, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        // Read during preload of the same word sees the old contents.
        access("ld18_pl",  1'b1, 1'b0, 64'h18, 2'b11, 64'h0, 1'b1, 7'd3, 64'h77, 64'h55, 1'b0);
        access("ld18b",    1'b1, 1'b0, 64'h18, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h77, 1'b0);
        // Half and word stores into upper lanes.
        access("sth12",    1'b0, 1'b1, 64'h12, 2'b01, 64'h1234_ABCD, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("ld10b",    1'b1, 1'b0, 64'h10, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0000_0000_ABCD_0000, 1'b0);
        access("stw14",    1'b0, 1'b1, 64'h14, 2'b10, 64'hFFFF_FFFF_1122_3344, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("ld10c",    1'b1, 1'b0, 64'h10, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h1122_3344_ABCD_0000, 1'b0);
        // Last in-range word.
        access("st3f8",    1'b0, 1'b1, 64'h3F8, 2'b11, 64'hCAFE_F00D_0000_0001, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("ld3f8",    1'b1, 1'b0, 64'h3F8, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'hCAFE_F00D_0000_0001, 1'b0);
`ifdef DMEM_STATS_EN
        chk("rd_count", {48'd0, rd_count}, 64'(exp_rd_cnt));
        chk("wr_count", {48'd0, wr_count}, 64'(exp_wr_cnt));
`endif
        // Reset in the middle of a read stream.
        access("ld0_pre",  1'b1, 1'b0, 64'h0, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0123_FF67_89AB_CDEF, 1'b0);
        do_reset(1'b1);
`ifdef DMEM_STATS_EN
        chk("rd_count_rst", {48'd0, rd_count}, 64'd0);
        chk("wr_count_rst", {48'd0, wr_count}, 64'd0);
`endif
        access("ld0_z",    1'b1, 1'b0, 64'h0,   2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("ld8_z",    1'b1, 1'b0, 64'h8,   2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("ld10_z",   1'b1, 1'b0, 64'h10,  2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("ld18_z",   1'b1, 1'b0, 64'h18,  2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("ld3f8_z",  1'b1, 1'b0, 64'h3F8, 2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);
        access("idle_end", 1'b0, 1'b0, 64'h0,   2'b11, 64'h0, 1'b0, 7'd0, 64'h0, 64'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
